// File: rtl/disk_nibble_writer_if.sv
// ============================================================================
// disk_nibble_writer_if : track-buffer write port (request/address/data/ack)
// Rev 1.0
// ============================================================================
`default_nettype none

interface disk_nibble_writer_if #(
  parameter int POS_WIDTH = 13
) ();
  logic                 wr_req_o;
  logic [POS_WIDTH-1:0] wr_addr_o;
  logic [7:0]           wr_data_o;
  logic                 wr_ack_i;

  modport master (
    output wr_req_o,
    output wr_addr_o,
    output wr_data_o,
    input  wr_ack_i
  );

  modport slave (
    input  wr_req_o,
    input  wr_addr_o,
    input  wr_data_o,
    output wr_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/disk_nibble_writer.sv
// ============================================================================
// disk_nibble_writer : Disk II write path, timed nibble commits into track buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module disk_nibble_writer #(
  parameter int TRACK_LEN  = 6656,
  parameter int POS_WIDTH  = 13,
  parameter int SLOT_US    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                 clk_logic,
  input  wire logic                 system_reset_n,
  input  wire logic                 us_tick_i,
  input  wire logic                 drive_active_i,
  input  wire logic                 write_mode_i,
  input  wire logic                 write_reg_i,
  input  wire logic [7:0]           data_i,
  input  wire logic [POS_WIDTH-1:0] track_pos_i,
  disk_nibble_writer_if.master      wr_port,
  output logic [POS_WIDTH-1:0]      pos_o,
  output logic                      write_active_o,
  output logic                      dirty_o,
  input  wire logic                 dirty_clr_i,
  output logic                      underrun_o,
  output logic                      overflow_o
);

  localparam int c_slot_w = $clog2(SLOT_US);
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_writing = 2'd1;
  localparam logic [1:0] c_st_flush   = 2'd2;

  logic [1:0]             r_state;
  logic [POS_WIDTH-1:0]   r_pos;
  logic [c_slot_w-1:0]    r_slot;
  logic [7:0]             r_latch;
  logic                   r_pending;
  logic                   r_dirty;
  logic                   r_underrun;
  logic                   r_overflow;
  logic [POS_WIDTH+7:0]   r_mem [FIFO_DEPTH];
  logic [c_ptr_w:0]       r_wr_ptr;
  logic [c_ptr_w:0]       r_rd_ptr;

  logic                   w_go;
  logic                   w_cell_end;
  logic [POS_WIDTH-1:0]   w_pos_next;
  logic                   w_push;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_accept;
  logic                   w_drop;
  logic [POS_WIDTH+7:0]   w_head;

  assign w_go       = write_mode_i & drive_active_i;
  assign w_cell_end = (r_state == c_st_writing) & w_go & us_tick_i &
                      (r_slot == c_slot_w'(SLOT_US - 1));
  assign w_pos_next = (r_pos == POS_WIDTH'(TRACK_LEN - 1)) ? '0 : r_pos + POS_WIDTH'(1);
  assign w_push     = r_pending & (w_cell_end | (r_state == c_st_flush));

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                    (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
  assign w_pop    = ~w_empty & wr_port.wr_ack_i;
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;
  assign w_head   = r_mem[r_rd_ptr[c_ptr_w-1:0]];

  assign wr_port.wr_req_o  = ~w_empty;
  assign wr_port.wr_addr_o = w_empty ? '0 : w_head[POS_WIDTH+7:8];
  assign wr_port.wr_data_o = w_empty ? '0 : w_head[7:0];

  assign pos_o          = r_pos;
  assign write_active_o = (r_state == c_st_writing);
  assign dirty_o        = r_dirty;
  assign underrun_o     = r_underrun;
  assign overflow_o     = r_overflow;

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state    <= c_st_idle;
      r_pos      <= '0;
      r_slot     <= '0;
      r_latch    <= '0;
      r_pending  <= 1'b0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_go) begin
            r_state    <= c_st_writing;
            r_pos      <= track_pos_i;
            r_slot     <= '0;
            r_pending  <= 1'b0;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
        c_st_writing: begin
          if (!w_go) begin
            r_state <= c_st_flush;
          end else if (us_tick_i) begin
            r_slot <= w_cell_end ? '0 : r_slot + c_slot_w'(1);
          end
          if (w_cell_end) begin
            r_pos     <= w_pos_next;
            r_pending <= 1'b0;
            if (!r_pending) r_underrun <= 1'b1;
          end
          // A store on the cell-end cycle becomes pending for the next cell.
          if (write_reg_i) begin
            r_latch   <= data_i;
            r_pending <= 1'b1;
          end
        end
        c_st_flush: begin
          if (r_pending) r_pos <= w_pos_next;
          r_pending <= 1'b0;
          r_state   <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dirty  <= 1'b0;
    end else begin
      if (w_accept)         r_wr_ptr <= r_wr_ptr + (c_ptr_w + 1)'(1);
      if (w_pop)            r_rd_ptr <= r_rd_ptr + (c_ptr_w + 1)'(1);
      if (w_accept)         r_dirty  <= 1'b1;
      else if (dirty_clr_i) r_dirty  <= 1'b0;
    end
  end

  always_ff @(posedge clk_logic) begin
    if (w_accept) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= {r_pos, r_latch};
  end

endmodule

`default_nettype wire
